// File: rtl/dldo_switch_ctrl.sv
// dldo_switch_ctrl: power-switch array actuator for the digital LDO.
// Steps a saturating count of enabled PMOS switches up or down according to
// the comparator decision, with a step size set by the active loop mode.
// In fine mode a steady limit cycle (repeated direction reversals) freezes
// the array and raises settled until the dither breaks or the mode changes.
module dldo_switch_ctrl #(
  parameter int NSW         = 64,
  parameter int CW          = 7,
  parameter int RESET_COUNT = 32,
  parameter int COARSE_STEP = 8,
  parameter int MEDIUM_STEP = 4,
  parameter int FINE_STEP   = 1,
  parameter int UPDATE_DIV  = 2,
  parameter int DITHER_N    = 4,
  parameter int LOCK_EXIT   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           coarse_loop,
  input  logic           medium_loop,
  input  logic           fine_loop,
  input  logic           cmp_low,
  output logic [CW-1:0]  sw_count,
  output logic [NSW-1:0] sw_therm,
  output logic           at_max,
  output logic           at_min,
  output logic           settled,
  output logic           mode_err
);

  localparam int DIV_W  = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int REV_W  = $clog2(DITHER_N + 1);
  localparam int EXIT_W = $clog2(LOCK_EXIT + 1);

  localparam logic [CW:0]     NSW_X     = (CW+1)'(NSW);
  localparam logic [CW-1:0]   NSW_C     = CW'(NSW);
  localparam logic [CW-1:0]   RST_CNT   = CW'(RESET_COUNT);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(UPDATE_DIV - 1);
  localparam logic [REV_W-1:0]  DITHER_V  = REV_W'(DITHER_N);
  localparam logic [EXIT_W-1:0] EXIT_V    = EXIT_W'(LOCK_EXIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t              state_r, state_n;
  logic [CW-1:0]       sw_count_r, sw_count_n;
  logic [DIV_W-1:0]    div_r, div_n;
  logic [REV_W-1:0]    rev_cnt_r, rev_cnt_n;
  logic [EXIT_W-1:0]   same_cnt_r, same_cnt_n;
  logic                dir_q_r, dir_q_n;
  logic                mode_err_r, mode_err_n;
  logic                settled_r, settled_n;
  logic                at_max_r, at_min_r;

  logic [1:0]          en_cnt_s;
  logic                multi_s;
  logic                none_s;
  logic [CW-1:0]       step_s;
  logic [CW:0]         sum_s;
  logic [CW-1:0]       up_cnt_s;
  logic [CW-1:0]       down_cnt_s;
  logic [REV_W-1:0]    rev_inc_s;
  logic [EXIT_W-1:0]   same_inc_s;
  logic [NSW-1:0]      sw_therm_s;

  // Enable population and the step size of the (single) active mode.
  always_comb begin
    en_cnt_s = {1'b0, coarse_loop} + {1'b0, medium_loop} + {1'b0, fine_loop};
    multi_s  = (en_cnt_s >= 2'd2);
    none_s   = (en_cnt_s == 2'd0);
    if (coarse_loop) begin
      step_s = CW'(COARSE_STEP);
    end else if (medium_loop) begin
      step_s = CW'(MEDIUM_STEP);
    end else begin
      step_s = CW'(FINE_STEP);
    end
  end

  // Saturating up/down candidates; the sum is one bit wider so it never wraps.
  always_comb begin
    sum_s = {1'b0, sw_count_r} + {1'b0, step_s};
    if (sum_s > NSW_X) begin
      up_cnt_s = NSW_C;
    end else begin
      up_cnt_s = sum_s[CW-1:0];
    end
    if (step_s > sw_count_r) begin
      down_cnt_s = '0;
    end else begin
      down_cnt_s = sw_count_r - step_s;
    end
    rev_inc_s  = rev_cnt_r + REV_W'(1);
    same_inc_s = same_cnt_r + EXIT_W'(1);
  end

  // Next-state and counter update; a multi-enable edge freezes everything.
  always_comb begin
    state_n    = state_r;
    sw_count_n = sw_count_r;
    div_n      = div_r;
    rev_cnt_n  = rev_cnt_r;
    same_cnt_n = same_cnt_r;
    dir_q_n    = dir_q_r;
    mode_err_n = 1'b0;
    if (multi_s) begin
      mode_err_n = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!none_s) begin
            state_n   = ST_STEP;
            div_n     = '0;
            rev_cnt_n = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_STEP: begin
          if (none_s) begin
            state_n = ST_IDLE;
          end else if (div_r == DIV_LAST) begin
            div_n   = '0;
            dir_q_n = cmp_low;
            if (cmp_low) begin
              sw_count_n = up_cnt_s;
            end else begin
              sw_count_n = down_cnt_s;
            end
            // Only fine-mode updates contribute to limit-cycle detection.
            if (fine_loop && (cmp_low != dir_q_r)) begin
              rev_cnt_n = rev_inc_s;
              if (rev_inc_s == DITHER_V) begin
                state_n    = ST_LOCK;
                same_cnt_n = '0;
              end else begin
                state_n = ST_STEP;
              end
            end else begin
              rev_cnt_n = '0;
            end
          end else begin
            div_n = div_r + DIV_W'(1);
          end
        end
        ST_LOCK: begin
          if (none_s) begin
            state_n = ST_IDLE;
          end else if (coarse_loop || medium_loop) begin
            state_n    = ST_STEP;
            div_n      = '0;
            rev_cnt_n  = '0;
            same_cnt_n = '0;
          end else if (cmp_low == dir_q_r) begin
            // A run of same-polarity samples means the loop has drifted off lock.
            if (same_inc_s == EXIT_V) begin
              state_n    = ST_STEP;
              div_n      = '0;
              rev_cnt_n  = '0;
              same_cnt_n = '0;
            end else begin
              same_cnt_n = same_inc_s;
            end
          end else begin
            same_cnt_n = '0;
            dir_q_n    = cmp_low;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
    settled_n = (state_n == ST_LOCK);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sw_count_r <= RST_CNT;
      div_r      <= '0;
      rev_cnt_r  <= '0;
      same_cnt_r <= '0;
      dir_q_r    <= 1'b0;
      mode_err_r <= 1'b0;
      settled_r  <= 1'b0;
      at_max_r   <= (RST_CNT == NSW_C);
      at_min_r   <= (RST_CNT == '0);
    end else begin
      state_r    <= state_n;
      sw_count_r <= sw_count_n;
      div_r      <= div_n;
      rev_cnt_r  <= rev_cnt_n;
      same_cnt_r <= same_cnt_n;
      dir_q_r    <= dir_q_n;
      mode_err_r <= mode_err_n;
      settled_r  <= settled_n;
      at_max_r   <= (sw_count_n == NSW_C);
      at_min_r   <= (sw_count_n == '0);
    end
  end

  // Thermometer decode of the registered count.
  always_comb begin
    sw_therm_s = '0;
    for (int i = 0; i < NSW; i++) begin
      sw_therm_s[i] = (32'(i) < 32'(sw_count_r));
    end
  end

  assign sw_count = sw_count_r;
  assign sw_therm = sw_therm_s;
  assign at_max   = at_max_r;
  assign at_min   = at_min_r;
  assign settled  = settled_r;
  assign mode_err = mode_err_r;

endmodule

// File: tb/tb_dldo_switch_ctrl.sv
// Directed bench for dldo_switch_ctrl: a vector table for reset, ramps and
// mode_err, plus hand-written sequences for dither lock and reset in lock.
module tb_dldo_switch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coarse_loop = 1'b0;
  logic        medium_loop = 1'b0;
  logic        fine_loop = 1'b0;
  logic        cmp_low = 1'b0;
  logic [6:0]  sw_count;
  logic [63:0] sw_therm;
  logic        at_max;
  logic        at_min;
  logic        settled;
  logic        mode_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic rst;
    logic c;
    logic m;
    logic f;
    logic cmp;
    int   exp_cnt;
    logic exp_set;
    logic exp_me;
  } vec_t;

  vec_t vecs[$];

  dldo_switch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .coarse_loop (coarse_loop),
    .medium_loop (medium_loop),
    .fine_loop   (fine_loop),
    .cmp_low     (cmp_low),
    .sw_count    (sw_count),
    .sw_therm    (sw_therm),
    .at_max      (at_max),
    .at_min      (at_min),
    .settled     (settled),
    .mode_err    (mode_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(logic r, logic c, logic m, logic f, logic cp,
                               int ec, logic es, logic em);
    vec_t v;
    v.rst = r; v.c = c; v.m = m; v.f = f; v.cmp = cp;
    v.exp_cnt = ec; v.exp_set = es; v.exp_me = em;
    return v;
  endfunction

  task automatic cyc(input logic r, input logic c, input logic m,
                     input logic f, input logic cp);
    rst = r; coarse_loop = c; medium_loop = m; fine_loop = f; cmp_low = cp;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int ec, input logic es, input logic em);
    logic [63:0] et;
    if (ec >= 64) et = {64{1'b1}};
    else et = (64'd1 << ec) - 64'd1;
    total++;
    if (int'(sw_count) != ec) begin
      bad++; $display("FAIL %s sw_count got=%0d want=%0d", tag, sw_count, ec);
    end
    total++;
    if (sw_therm !== et) begin
      bad++; $display("FAIL %s sw_therm got=%h want=%h", tag, sw_therm, et);
    end
    total++;
    if (at_max !== (ec == 64)) begin
      bad++; $display("FAIL %s at_max got=%b want=%b", tag, at_max, (ec == 64));
    end
    total++;
    if (at_min !== (ec == 0)) begin
      bad++; $display("FAIL %s at_min got=%b want=%b", tag, at_min, (ec == 0));
    end
    total++;
    if (settled !== es) begin
      bad++; $display("FAIL %s settled got=%b want=%b", tag, settled, es);
    end
    total++;
    if (mode_err !== em) begin
      bad++; $display("FAIL %s mode_err got=%b want=%b", tag, mode_err, em);
    end
  endtask

  initial begin
    int e;
    logic upd_cmp [9];
    int   upd_cnt [9];

    // Reset held two cycles, then idle hold with cmp_low toggled.
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b0, 1'b0));
    // Coarse up-ramp: +8 every second edge from E2, clamped at 64.
    for (int i = 0; i < 12; i++) begin
      e = 32 + 8 * (i / 2);
      if (e > 64) e = 64;
      vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, e, 1'b0, 1'b0));
    end
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b0, 1'b0));
    // Medium down-ramp: -4 every second edge, floored at 0.
    for (int i = 0; i < 19; i++) begin
      e = 32 - 4 * (i / 2);
      if (e < 0) e = 0;
      vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e, 1'b0, 1'b0));
    end
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b0, 1'b0));
    // mode_err: coarse to 40, three double-enable edges freeze, then resume.
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 40, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 40, 1'b0, 1'b1));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 40, 1'b0, 1'b1));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 40, 1'b0, 1'b1));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 40, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 48, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 48, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 56, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].c, vecs[i].m, vecs[i].f, vecs[i].cmp);
      chk($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_set, vecs[i].exp_me);
    end

    // Fine dither lock: reversals at E2, E4, E6, E8 (dir_q starts at 0).
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  chk("dith_rst", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("dith_e0", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("dith_e1", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("dith_e2", 33, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  chk("dith_e3", 33, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  chk("dith_e4", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("dith_e5", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("dith_e6", 33, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  chk("dith_e7", 33, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  chk("dith_lock", 32, 1'b1, 1'b0);
    // In LOCK with dir_q=0: first cmp_low=1 re-arms dir_q, three more exit.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("lock_s0", 32, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("lock_s1", 32, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("lock_s2", 32, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("lock_exit", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("resume_e1", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("resume_e2", 33, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("resume_e3", 33, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("resume_e4", 34, 1'b0, 1'b0);

    // Reset mid-lock: coarse to 40, fine up to 45, then dither and lock at 45.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  chk("rl_rst", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);  chk("rl_c0", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);  chk("rl_c1", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);  chk("rl_c2", 40, 1'b0, 1'b0);
    upd_cmp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    upd_cnt = '{41, 42, 43, 44, 45, 44, 45, 44, 45};
    for (int u = 0; u < 9; u++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, upd_cmp[u]);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, upd_cmp[u]);
      chk($sformatf("rl_upd%0d", u), upd_cnt[u], (u == 8), 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);  chk("rl_pulse", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  chk("rl_idle0", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  chk("rl_idle1", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("rl_f0", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("rl_f1", 32, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  chk("rl_f2", 33, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
